// File: rtl/bsram_port_arbiter.sv
// Round-robin arbiter sharing one BSRAM port among N_REQ requesters; a tag
// pipeline matched to the RAM read latency routes each response back to its requester.
module bsram_port_arbiter #(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned A_SIZE   = 13,
  parameter int unsigned W_SIZE   = 16,
  parameter int unsigned DEPTH    = 6144,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*A_SIZE-1:0]  req_addr,
  input  logic [N_REQ*W_SIZE-1:0]  req_wdata,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic                     rsp_err,
  output logic                     rsp_we,
  output logic [W_SIZE-1:0]        rsp_rdata,
  output logic                     mem_ce,
  output logic                     mem_oce,
  output logic                     mem_wre,
  output logic [A_SIZE-1:0]        mem_ad,
  output logic [W_SIZE-1:0]        mem_din,
  input  logic [W_SIZE-1:0]        mem_dout
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned LAST  = READ_LAT - 1;

  logic [IDX_W-1:0]    ptr;
  logic                gnt_any;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_we;
  logic [A_SIZE-1:0]   gnt_addr;
  logic [W_SIZE-1:0]   gnt_wdata;
  logic                gnt_oor;
  logic                accept;

  logic [READ_LAT-1:0] tag_v;
  logic [READ_LAT-1:0] tag_we;
  logic [READ_LAT-1:0] tag_err;
  logic [IDX_W-1:0]    tag_idx [READ_LAT];

  // First valid requester after the last-granted one wins.
  always_comb begin
    int unsigned cand;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!gnt_any && req_valid[IDX_W'(cand)]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    gnt_we    = 1'b0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == gnt_idx) begin
        gnt_we    = req_we[i];
        gnt_addr  = req_addr[i*A_SIZE +: A_SIZE];
        gnt_wdata = req_wdata[i*W_SIZE +: W_SIZE];
      end
    end
  end

  assign gnt_oor = (32'(gnt_addr) >= DEPTH);
  assign accept  = gnt_any & reset_n;

  // Issue in the grant cycle; out-of-range accesses never enable the RAM.
  always_comb begin
    req_ready = accept ? (N_REQ'(1) << gnt_idx) : '0;
    mem_ce    = accept & ~gnt_oor;
    mem_wre   = accept & ~gnt_oor & gnt_we;
    mem_ad    = accept ? gnt_addr : '0;
    mem_din   = accept ? gnt_wdata : '0;
  end

  assign mem_oce = (READ_LAT == 2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= IDX_W'(N_REQ - 1);
    end else if (accept) begin
      ptr <= gnt_idx;
    end
  end

  // Never stalls: idle cycles push bubbles so responses align with RAM data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_v   <= '0;
      tag_we  <= '0;
      tag_err <= '0;
      for (int unsigned s = 0; s < READ_LAT; s++) tag_idx[s] <= '0;
    end else begin
      tag_v[0]   <= accept;
      tag_we[0]  <= accept & gnt_we;
      tag_err[0] <= accept & gnt_oor;
      tag_idx[0] <= gnt_idx;
      for (int unsigned s = 1; s < READ_LAT; s++) begin
        tag_v[s]   <= tag_v[s-1];
        tag_we[s]  <= tag_we[s-1];
        tag_err[s] <= tag_err[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end
    end
  end

  always_comb begin
    rsp_valid = tag_v[LAST] ? (N_REQ'(1) << tag_idx[LAST]) : '0;
    rsp_we    = tag_v[LAST] & tag_we[LAST];
    rsp_err   = tag_v[LAST] & tag_err[LAST];
    rsp_rdata = (tag_v[LAST] & ~tag_we[LAST] & ~tag_err[LAST]) ? mem_dout : '0;
  end

endmodule

// File: tb/tb_bsram_port_arbiter.sv
// Bench for bsram_port_arbiter: READ_LAT=1 and READ_LAT=2 instances share stimulus;
// directed vector table, reset mid-flight sequence and random traffic vs. a transaction model.
module tb_bsram_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 13;
  localparam int DW = 16;
  localparam int DEPTH = 6144;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_we;
  logic [AW-1:0]   ra [N];
  logic [DW-1:0]   rd [N];
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;

  logic [N-1:0]  req_ready1, rsp_valid1, req_ready2, rsp_valid2;
  logic          rsp_err1, rsp_we1, rsp_err2, rsp_we2;
  logic [DW-1:0] rsp_rdata1, rsp_rdata2, mem_din1, mem_din2, mem_dout1, mem_dout2;
  logic          mem_ce1, mem_oce1, mem_wre1, mem_ce2, mem_oce2, mem_wre2;
  logic [AW-1:0] mem_ad1, mem_ad2;

  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = ra[i];
      req_wdata[i*DW +: DW] = rd[i];
    end
  end

  bsram_port_arbiter #(.N_REQ(N), .A_SIZE(AW), .W_SIZE(DW), .DEPTH(DEPTH), .READ_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_err(rsp_err1), .rsp_we(rsp_we1), .rsp_rdata(rsp_rdata1),
    .mem_ce(mem_ce1), .mem_oce(mem_oce1), .mem_wre(mem_wre1), .mem_ad(mem_ad1),
    .mem_din(mem_din1), .mem_dout(mem_dout1));

  bsram_port_arbiter #(.N_REQ(N), .A_SIZE(AW), .W_SIZE(DW), .DEPTH(DEPTH), .READ_LAT(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready2),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_err(rsp_err2), .rsp_we(rsp_we2), .rsp_rdata(rsp_rdata2),
    .mem_ce(mem_ce2), .mem_oce(mem_oce2), .mem_wre(mem_wre2), .mem_ad(mem_ad2),
    .mem_din(mem_din2), .mem_dout(mem_dout2));

  function automatic logic [DW-1:0] init_val(input int a);
    case (a)
      16'h0010: return 16'hBEEF;
      16'h0001: return 16'h0101;
      16'h0002: return 16'h0202;
      default:  return DW'(a * 8) ^ 16'h5A3C;
    endcase
  endfunction

  // Block RAM models: bypass (1 clk) and output-register (2 clk) read paths.
  logic [DW-1:0] ram1 [8192];
  logic [DW-1:0] ram2 [8192];
  logic [DW-1:0] r1_q, r2_a, r2_q;
  logic          ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 8192; i++) begin
        ram1[i] <= init_val(i);
        ram2[i] <= init_val(i);
      end
      ram_loaded <= 1'b1;
    end else begin
      if (mem_ce1) begin
        if (mem_wre1) ram1[mem_ad1] <= mem_din1;
        else          r1_q <= ram1[mem_ad1];
      end
      if (mem_ce2) begin
        if (mem_wre2) ram2[mem_ad2] <= mem_din2;
        else          r2_a <= ram2[mem_ad2];
      end
      if (mem_oce2) r2_q <= r2_a;
    end
  end
  assign mem_dout1 = r1_q;
  assign mem_dout2 = r2_q;

  // Transaction-level reference model.
  typedef struct {
    int            acc;
    int            idx;
    logic          we;
    logic          err;
    logic [DW-1:0] data;
  } rec_t;

  rec_t          q[$];
  logic [DW-1:0] shadow [8192];
  int            last_gnt;
  int            last_g;
  int            cyc;
  int            checks;
  int            errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_grant(input logic [N-1:0] v, input int last);
    int best, bd, d;
    best = -1;
    bd   = N + 1;
    for (int i = 0; i < N; i++) begin
      d = (i - last - 1 + 2 * N) % N;
      if (v[i] && d < bd) begin
        bd   = d;
        best = i;
      end
    end
    return best;
  endfunction

  task automatic check_cycle();
    int            g;
    logic [N-1:0]  er;
    logic          oor;
    logic [N-1:0]  ev;
    logic          ewe, eerr;
    logic [DW-1:0] ed;
    rec_t          r;
    chk("oce_l1", 32'(mem_oce1), 0);
    chk("oce_l2", 32'(mem_oce2), 1);
    if (!reset_n) begin
      q.delete();
      last_gnt = N - 1;
      last_g   = -1;
      chk("rst_ready_l1", 32'(req_ready1), 0);  chk("rst_ready_l2", 32'(req_ready2), 0);
      chk("rst_rspv_l1", 32'(rsp_valid1), 0);   chk("rst_rspv_l2", 32'(rsp_valid2), 0);
      chk("rst_err_l1", 32'(rsp_err1), 0);      chk("rst_err_l2", 32'(rsp_err2), 0);
      chk("rst_we_l1", 32'(rsp_we1), 0);        chk("rst_we_l2", 32'(rsp_we2), 0);
      chk("rst_rdata_l1", 32'(rsp_rdata1), 0);  chk("rst_rdata_l2", 32'(rsp_rdata2), 0);
      chk("rst_ce_l1", 32'(mem_ce1), 0);        chk("rst_ce_l2", 32'(mem_ce2), 0);
      chk("rst_wre_l1", 32'(mem_wre1), 0);      chk("rst_wre_l2", 32'(mem_wre2), 0);
    end else begin
      while (q.size() > 0 && q[0].acc < cyc - 2) void'(q.pop_front());
      for (int lat = 1; lat <= 2; lat++) begin
        ev = '0; ewe = 1'b0; eerr = 1'b0; ed = '0;
        foreach (q[j]) begin
          if (q[j].acc == cyc - lat) begin
            ev   = N'(1) << q[j].idx;
            ewe  = q[j].we;
            eerr = q[j].err;
            ed   = q[j].data;
          end
        end
        if (lat == 1) begin
          chk("rsp_valid_l1", 32'(rsp_valid1), 32'(ev));
          chk("rsp_we_l1", 32'(rsp_we1), 32'(ewe));
          chk("rsp_err_l1", 32'(rsp_err1), 32'(eerr));
          chk("rsp_rdata_l1", 32'(rsp_rdata1), 32'(ed));
        end else begin
          chk("rsp_valid_l2", 32'(rsp_valid2), 32'(ev));
          chk("rsp_we_l2", 32'(rsp_we2), 32'(ewe));
          chk("rsp_err_l2", 32'(rsp_err2), 32'(eerr));
          chk("rsp_rdata_l2", 32'(rsp_rdata2), 32'(ed));
        end
      end
      g      = exp_grant(req_valid, last_gnt);
      last_g = g;
      if (g < 0) begin
        chk("ready_l1", 32'(req_ready1), 0);  chk("ready_l2", 32'(req_ready2), 0);
        chk("ce_l1", 32'(mem_ce1), 0);        chk("ce_l2", 32'(mem_ce2), 0);
        chk("wre_l1", 32'(mem_wre1), 0);      chk("wre_l2", 32'(mem_wre2), 0);
        chk("ad_l1", 32'(mem_ad1), 0);        chk("ad_l2", 32'(mem_ad2), 0);
        chk("din_l1", 32'(mem_din1), 0);      chk("din_l2", 32'(mem_din2), 0);
      end else begin
        er  = N'(1) << g;
        oor = (int'(ra[g]) >= DEPTH);
        chk("ready_l1", 32'(req_ready1), 32'(er));          chk("ready_l2", 32'(req_ready2), 32'(er));
        chk("ce_l1", 32'(mem_ce1), 32'(!oor));              chk("ce_l2", 32'(mem_ce2), 32'(!oor));
        chk("wre_l1", 32'(mem_wre1), 32'(req_we[g] && !oor)); chk("wre_l2", 32'(mem_wre2), 32'(req_we[g] && !oor));
        chk("ad_l1", 32'(mem_ad1), 32'(ra[g]));             chk("ad_l2", 32'(mem_ad2), 32'(ra[g]));
        chk("din_l1", 32'(mem_din1), 32'(rd[g]));           chk("din_l2", 32'(mem_din2), 32'(rd[g]));
        r.acc  = cyc;
        r.idx  = g;
        r.we   = req_we[g];
        r.err  = oor;
        r.data = (req_we[g] || oor) ? '0 : shadow[ra[g]];
        q.push_back(r);
        if (req_we[g] && !oor) shadow[ra[g]] = rd[g];
        last_gnt = g;
      end
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 3:    return AW'($urandom_range(0, 15));
      1:       return AW'($urandom_range(DEPTH - 2, DEPTH + 1));
      default: return AW'($urandom_range(0, 8191));
    endcase
  endfunction

  typedef struct {
    logic [N-1:0]  v;
    logic [N-1:0]  we;
    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];
    logic [N-1:0]  rdy;
    logic          ce;
    logic          wre;
    logic [AW-1:0] ad;
    logic [DW-1:0] din;
  } vec_t;

  function automatic vec_t mk(input logic [N-1:0] v, input logic [N-1:0] we,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                              input logic [N-1:0] rdy, input logic ce, input logic wre,
                              input logic [AW-1:0] ad, input logic [DW-1:0] din);
    vec_t t;
    t.v = v; t.we = we;
    t.a[0] = a0; t.a[1] = a1; t.a[2] = a2;
    t.d[0] = d0; t.d[1] = d1; t.d[2] = d2;
    t.rdy = rdy; t.ce = ce; t.wre = wre; t.ad = ad; t.din = din;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    tbl.push_back(mk(3'b111, 3'b000, 13'h20, 13'h21, 13'h22, 0, 0, 0, 3'b001, 1, 0, 13'h20, 0));
    tbl.push_back(mk(3'b111, 3'b000, 13'h20, 13'h21, 13'h22, 0, 0, 0, 3'b010, 1, 0, 13'h21, 0));
    tbl.push_back(mk(3'b111, 3'b000, 13'h20, 13'h21, 13'h22, 0, 0, 0, 3'b100, 1, 0, 13'h22, 0));
    tbl.push_back(mk(3'b111, 3'b000, 13'h20, 13'h21, 13'h22, 0, 0, 0, 3'b001, 1, 0, 13'h20, 0));
    tbl.push_back(mk(3'b111, 3'b000, 13'h20, 13'h21, 13'h22, 0, 0, 0, 3'b010, 1, 0, 13'h21, 0));
    tbl.push_back(mk(3'b111, 3'b000, 13'h20, 13'h21, 13'h22, 0, 0, 0, 3'b100, 1, 0, 13'h22, 0));
    tbl.push_back(mk(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(3'b001, 3'b000, 13'h10, 0, 0, 0, 0, 0, 3'b001, 1, 0, 13'h10, 0));
    tbl.push_back(mk(3'b010, 3'b010, 0, 13'h17FF, 0, 0, 16'h1234, 0, 3'b010, 1, 1, 13'h17FF, 16'h1234));
    tbl.push_back(mk(3'b100, 3'b000, 0, 0, 13'h17FF, 0, 0, 0, 3'b100, 1, 0, 13'h17FF, 0));
    tbl.push_back(mk(3'b001, 3'b001, 13'h1800, 0, 0, 16'hAAAA, 0, 0, 3'b001, 0, 0, 13'h1800, 16'hAAAA));
    tbl.push_back(mk(3'b100, 3'b000, 0, 0, 13'h1800, 0, 0, 0, 3'b100, 0, 0, 13'h1800, 0));
    tbl.push_back(mk(3'b011, 3'b000, 13'h1, 13'h2, 0, 0, 0, 0, 3'b001, 1, 0, 13'h1, 0));
    tbl.push_back(mk(3'b010, 3'b000, 0, 13'h2, 0, 0, 0, 0, 3'b010, 1, 0, 13'h2, 0));
    tbl.push_back(mk(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));

    checks = 0; errors = 0; cyc = 0; last_gnt = N - 1; last_g = -1;
    for (int i = 0; i < 8192; i++) shadow[i] = init_val(i);
    reset_n = 1'b0; req_valid = '0; req_we = '0;
    for (int i = 0; i < N; i++) begin ra[i] = '0; rd[i] = '0; end

    @(posedge clk); #1;
    step();
    step();
    reset_n = 1'b1;

    // Directed vectors.
    foreach (tbl[k]) begin
      req_valid = tbl[k].v;
      req_we    = tbl[k].we;
      for (int i = 0; i < N; i++) begin ra[i] = tbl[k].a[i]; rd[i] = tbl[k].d[i]; end
      @(negedge clk);
      chk($sformatf("vec%0d_ready", k), 32'(req_ready1), 32'(tbl[k].rdy));
      chk($sformatf("vec%0d_ce", k), 32'(mem_ce1), 32'(tbl[k].ce));
      chk($sformatf("vec%0d_wre", k), 32'(mem_wre1), 32'(tbl[k].wre));
      chk($sformatf("vec%0d_ad", k), 32'(mem_ad1), 32'(tbl[k].ad));
      chk($sformatf("vec%0d_din", k), 32'(mem_din1), 32'(tbl[k].din));
      check_cycle();
      @(posedge clk); #1;
    end
    chk("ram_oor_l1", 32'(ram1[13'h1800]), 32'(init_val(16'h1800)));
    chk("ram_oor_l2", 32'(ram2[13'h1800]), 32'(init_val(16'h1800)));
    chk("ram_wr_l1", 32'(ram1[13'h17FF]), 32'h1234);

    // Reset while a read is in flight; no response may follow.
    req_valid = 3'b111; req_we = '0;
    ra[0] = 13'h5; ra[1] = 13'h6; ra[2] = 13'h7;
    step();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant_l1", 32'(req_ready1), 32'h1);
    chk("post_rst_grant_l2", 32'(req_ready2), 32'h1);
    check_cycle();
    @(posedge clk); #1;
    req_valid = '0;
    for (int n = 0; n < 3; n++) step();

    // Random traffic; requesters hold their request until accepted.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      check_cycle();
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_g == i) begin
          req_valid[i] = ($urandom_range(0, 9) < 6);
          req_we[i]    = 1'($urandom_range(0, 1));
          ra[i]        = rand_addr();
          rd[i]        = DW'($urandom);
        end
      end
    end
    req_valid = '0;
    for (int n = 0; n < 4; n++) step();
    chk("ram_oor_end_l1", 32'(ram1[13'h1800]), 32'(shadow[13'h1800]));
    chk("ram_oor_end_l2", 32'(ram2[13'h1801]), 32'(shadow[13'h1801]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsram_port_arbiter.md
Name: bsram_port_arbiter

Overview:
- Shares one port of the 16-bit, 13-bit-address dual-port block RAM between N_REQ requesters (e.g. CPU fetch, CPU data, DMA) using round-robin arbitration.
- Accepts at most one request per clock and issues it to the RAM port in the same cycle.
- Tracks in-flight accesses in a tag pipeline matched to RAM read latency, and routes each response to its originating requester.
- Out-of-range addresses are trapped with an error response instead of reaching the RAM.

Parameters:
N_REQ, 3, number of requesters (2..8)
A_SIZE, 13, address width
W_SIZE, 16, data width
DEPTH, 6144, valid words; address >= DEPTH is out of range
READ_LAT, 1, RAM read latency in clocks (1 = bypass output register, 2 = pipelined output register; only 1 or 2 legal)

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  request valid per requester
req_ready  out  N_REQ  grant/accept, at most one bit high
req_we  in  N_REQ  1 = write, 0 = read
req_addr  in  N_REQ*A_SIZE  packed addresses, requester i at [i*A_SIZE +: A_SIZE]
req_wdata  in  N_REQ*W_SIZE  packed write data
rsp_valid  out  N_REQ  one-cycle response strobe per requester
rsp_err  out  1  response carries out-of-range error
rsp_we  out  1  response is write acknowledge
rsp_rdata  out  W_SIZE  read data, shared by all requesters
mem_ce  out  1  RAM clock enable
mem_oce  out  1  RAM output register enable
mem_wre  out  1  RAM write enable
mem_ad  out  A_SIZE  RAM address
mem_din  out  W_SIZE  RAM write data
mem_dout  in  W_SIZE  RAM read data

Behaviour:
- Reset: async assert clears the round-robin pointer to N_REQ-1 (requester 0 highest priority) and clears all tag-pipeline valids.
  - While reset_n = 0: req_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_we = 0, rsp_rdata = 0, mem_ce = 0, mem_wre = 0.
  - Reset mid-operation drops in-flight responses; none are emitted after release.
- Arbitration (combinational):
  - Scan requesters starting at (ptr+1) mod N_REQ; the first with req_valid=1 gets req_ready=1.
  - No valid requests: req_ready = 0.
  - ptr updates to the granted index only on acceptance (valid & ready at a rising edge); otherwise it holds.
  - A requester that holds valid is served within N_REQ accepts; no starvation.
- Issue (combinational, same cycle as grant):
  - mem_ad, mem_din and mem_wre follow the granted requester.
  - mem_ce = 1 only if the grant exists and addr < DEPTH.
  - Out-of-range requests: mem_ce = 0, mem_wre = 0, so no RAM access or write occurs.
  - With no grant: mem_ce = 0, mem_wre = 0, mem_ad and mem_din = 0.
  - mem_oce = 1 when READ_LAT = 2, and 0 otherwise.
- Tag pipeline (READ_LAT stages):
  - Each accept pushes {valid=1, idx, we, err=(addr>=DEPTH)}; an idle cycle pushes valid=0.
  - The pipeline never stalls.
- Response (from last stage):
  - rsp_valid[idx] = 1 for exactly one cycle, in the cycle following READ_LAT rising edges after the accept edge.
  - rsp_we and rsp_err reflect the stage contents.
  - rsp_rdata = mem_dout for a successful read, and 0 for writes, errors, or no response.
  - Responses are in acceptance order. Requesters must always sink responses; there is no response backpressure.
- Throughput: one accept per cycle sustained, with back-to-back grants to different requesters. A requester may hold valid across its response and be re-granted when its turn comes.
- Simultaneous events: a new accept and an emitted response in the same cycle are independent and both occur.
- Inputs of a non-granted requester are ignored and must be held stable by the requester until accepted.

Test Plan:
- Single read after reset, READ_LAT=1: preload addr 0x0010 = 0xBEEF; req0 valid read at 0x0010 -> req_ready[0]=1 that cycle, mem_ce=1, mem_ad=0x0010; next cycle rsp_valid=3'b001, rsp_rdata=0xBEEF, rsp_err=0.
- Round-robin fairness: all three requesters hold valid for 6 cycles -> grant order 0,1,2,0,1,2; each rsp_valid bit pulses twice, in that order.
- Write then read: req1 writes 0x1234 to 0x17FF, then req2 reads 0x17FF -> write ack rsp_valid[1] with rsp_we=1, rsp_rdata=0; read returns 0x1234 on rsp_valid[2].
- Out of range: req0 writes 0xAAAA to 0x1800 (=6144) -> mem_ce=0, mem_wre=0; ack has rsp_err=1. A following read of 0x1800 returns rsp_err=1, rsp_rdata=0. RAM contents are unchanged.
- READ_LAT=2 pipelining: back-to-back reads of 0x0001 and 0x0002 (holding 0x0101 and 0x0202) from req0 and req1 -> mem_oce=1; responses appear 2 cycles after each accept on consecutive cycles, in order, with correct data.
- Reset mid-flight: accept a read, assert reset_n=0 before its response, release -> no rsp_valid pulse ever; the next grant goes to requester 0 when all are valid.
